// File: rtl/cpc_ram_pkg.sv
// -----------------------------------------------------------------------------
// cpc_ram_pkg
// Shared types and helpers for the CPC 512K expansion SRAM controller.
//   state_t        arbiter FSM states
//   map_t          result of the quadrant decode {ext, page}
//   CFG_SEL        D[7:6] pattern that marks a RAM-config OUT
//   MODE_*         RAM-config mode encodings
//   map_quadrant() maps a Z80 quadrant to an expansion page for a given mode
// -----------------------------------------------------------------------------
package cpc_ram_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DMA_ACC = 2'd1,
    DMA_ACK = 2'd2,
    ABORT   = 2'd3
  } state_t;

  typedef struct packed {
    logic       ext;   // 1 = quadrant served by expansion SRAM
    logic [1:0] page;  // 16K page inside the selected 64K bank
  } map_t;

  localparam logic [1:0] CFG_SEL = 2'b11;

  localparam logic [2:0] MODE_NONE    = 3'd0;  // all internal RAM
  localparam logic [2:0] MODE_TOP     = 3'd1;  // q3 -> p3
  localparam logic [2:0] MODE_ALL     = 3'd2;  // q0..q3 -> p0..p3
  localparam logic [2:0] MODE_TOP_ALT = 3'd3;  // q3 -> p3 (video stays internal)
  localparam logic [2:0] MODE_Q1_BASE = 3'd4;  // modes 4..7: q1 -> p(mode-4)

  function automatic map_t map_quadrant(input logic [2:0] mode, input logic [1:0] q);
    map_t m;
    m = '0;
    case (mode)
      MODE_NONE: m = '0;
      MODE_TOP, MODE_TOP_ALT: begin
        if (q == 2'd3) begin
          m.ext  = 1'b1;
          m.page = 2'd3;
        end
      end
      MODE_ALL: begin
        m.ext  = 1'b1;
        m.page = q;
      end
      default: begin
        // modes 4..7: page index is simply the low two mode bits (mode - 4)
        if (q == 2'd1) begin
          m.ext  = 1'b1;
          m.page = mode[1:0];
        end
      end
    endcase
    return m;
  endfunction

endpackage

// File: rtl/cpc_strobe_sync.sv
// -----------------------------------------------------------------------------
// cpc_strobe_sync
// Synchroniser for one asynchronous Z80-side strobe (already converted to
// active-high), with rising-edge detection.
//   clk    in  system clock
//   rst    in  asynchronous active-high reset
//   din    in  asynchronous strobe, active high
//   level  out 1 when every synchroniser stage holds 1
//   rise   out one-clock pulse on the rising edge of level
// Parameter STAGES (>=2) sets the flop-chain depth.
// -----------------------------------------------------------------------------
module cpc_strobe_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise
);

  logic [STAGES-1:0] chain_reg;
  logic              level_prev_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chain_reg      <= '0;
      level_prev_reg <= 1'b0;
    end else begin
      chain_reg      <= {chain_reg[STAGES-2:0], din};
      level_prev_reg <= level;
    end
  end

  // Requiring all stages high filters single-clock glitches on the bus strobes.
  assign level = &chain_reg;
  assign rise  = level & ~level_prev_reg;

endmodule

// File: rtl/cpc_ram_arbiter.sv
// -----------------------------------------------------------------------------
// cpc_ram_arbiter
// Controller for the CPC 512K expansion SRAM: decodes the RAM-config OUT into
// cfg_q, maps Z80 quadrants onto 16K SRAM pages, drives RAMDIS and arbitrates
// the SRAM between the Z80 (priority) and a DMA/debug port.
// Ports:
//   CLK, RESET            clock, asynchronous active-high reset
//   A, D                  Z80 address / data (D sampled for config writes)
//   IOREQ_B, WR_B, MREQ_B Z80 strobes, active low, asynchronous to CLK
//   RAMRD_B               gate-array RAM read strobe, active low
//   RAMDIS                1 = expansion serves the current access
//   READY                 Z80 wait line (0 = wait)
//   sram_a, ramcs_b, sram_we_b, sram_oe_b   SRAM interface
//   dma_req, dma_we, dma_addr, dma_ack      secondary access port
//   cfg_q                 config register {bank[2:0], mode[2:0]}
// Configuration macro WAIT_STATE_EN:
//   defined   - a CPU memory cycle arriving during a DMA access is stalled
//               with READY=0 until the DMA access finishes.
//   undefined - READY is always 1; the DMA access is aborted instead and the
//               held request is retried once MREQ_B is high again.
// -----------------------------------------------------------------------------
module cpc_ram_arbiter
  import cpc_ram_pkg::*;
#(
  parameter int         SYNC_STAGES = 2,
  parameter int         DMA_CYCLES  = 2,
  parameter logic [5:0] RESET_CFG   = 6'h00
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [15:0] A,
  input  logic [7:0]  D,
  input  logic        IOREQ_B,
  input  logic        WR_B,
  input  logic        MREQ_B,
  input  logic        RAMRD_B,
  output logic        RAMDIS,
  output logic        READY,
  output logic [18:0] sram_a,
  output logic        ramcs_b,
  output logic        sram_we_b,
  output logic        sram_oe_b,
  input  logic        dma_req,
  input  logic        dma_we,
  input  logic [18:0] dma_addr,
  output logic        dma_ack,
  output logic [5:0]  cfg_q
);

`ifdef WAIT_STATE_EN
  localparam bit WAIT_EN = 1'b1;
`else
  localparam bit WAIT_EN = 1'b0;
`endif

  localparam int NUM_STROBES = 3;
  localparam int S_IO_WR     = 0;  // OUT cycle: ~(IOREQ_B | WR_B)
  localparam int S_CPU_MEM   = 1;  // CPU memory cycle in progress
  localparam int S_DMA_GO    = 2;  // DMA pending and bus quiet

  // ---------------------------------------------------------------------------
  // Strobe synchronisers
  // ---------------------------------------------------------------------------
  logic [NUM_STROBES-1:0] strobe_in;
  logic [NUM_STROBES-1:0] strobe_level;
  logic [NUM_STROBES-1:0] strobe_rise;
  logic                   rise_unused;

  assign strobe_in[S_IO_WR]   = ~(IOREQ_B | WR_B);
  assign strobe_in[S_CPU_MEM] = ~MREQ_B;
  assign strobe_in[S_DMA_GO]  = dma_req & MREQ_B;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_STROBES; gi++) begin : g_sync
      cpc_strobe_sync #(
        .STAGES(SYNC_STAGES)
      ) u_sync (
        .clk  (CLK),
        .rst  (RESET),
        .din  (strobe_in[gi]),
        .level(strobe_level[gi]),
        .rise (strobe_rise[gi])
      );
    end
  endgenerate

  // Only the OUT strobe is edge-triggered; the others are used as levels.
  assign rise_unused = |strobe_rise[S_DMA_GO:S_CPU_MEM];

  logic cpu_hit;
  assign cpu_hit = strobe_level[S_CPU_MEM];

  // ---------------------------------------------------------------------------
  // Config register
  // ---------------------------------------------------------------------------
  logic [5:0] cfg_reg;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      cfg_reg <= RESET_CFG;
    end else if (strobe_rise[S_IO_WR] && !A[15] && (D[7:6] == CFG_SEL)) begin
      // A and D are still stable here: an OUT holds them for the whole strobe.
      cfg_reg <= D[5:0];
    end
  end

  assign cfg_q = cfg_reg;

  // ---------------------------------------------------------------------------
  // CPU path: purely combinational from the live bus and cfg_reg
  // ---------------------------------------------------------------------------
  map_t        cpu_map;
  logic [18:0] cpu_sram_a;
  logic        cpu_ramdis;
  logic        cpu_ramcs_b;

  assign cpu_map     = map_quadrant(cfg_reg[2:0], A[15:14]);
  assign cpu_sram_a  = {cfg_reg[5:3], cpu_map.page, A[13:0]};
  assign cpu_ramdis  = cpu_map.ext & ~MREQ_B;
  assign cpu_ramcs_b = ~cpu_map.ext | MREQ_B;

  // ---------------------------------------------------------------------------
  // Arbiter FSM
  // ---------------------------------------------------------------------------
  state_t     state_reg, state_next;
  logic [3:0] cnt_reg, cnt_next;
  logic       req_lost_reg, req_lost_next;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_reg    <= IDLE;
      cnt_reg      <= '0;
      req_lost_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      req_lost_reg <= req_lost_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    cnt_next      = cnt_reg;
    req_lost_next = req_lost_reg;
    case (state_reg)
      IDLE: begin
        // live dma_req as well: the synchronised copy lags a dropped request
        // right after an ack and would otherwise start a second access
        if (dma_req && strobe_level[S_DMA_GO]) begin
          state_next    = DMA_ACC;
          cnt_next      = 4'(DMA_CYCLES - 1);
          req_lost_next = 1'b0;
        end
      end
      DMA_ACC: begin
        if (!dma_req) begin
          req_lost_next = 1'b1;
        end
        if (!WAIT_EN && cpu_hit) begin
          state_next = ABORT;
        end else if (cnt_reg == 4'd0) begin
          // a request withdrawn mid-access still completes, silently
          state_next = (req_lost_reg || !dma_req) ? IDLE : DMA_ACK;
        end else begin
          cnt_next = cnt_reg - 4'd1;
        end
      end
      DMA_ACK: state_next = IDLE;
      ABORT:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output mux
  // ---------------------------------------------------------------------------
  logic dma_owns;

  // Without wait states the CPU takes the SRAM back in the very clock the
  // synchronised MREQ_B is seen, before the FSM reaches ABORT.
  assign dma_owns = (state_reg == DMA_ACC) && (WAIT_EN || !cpu_hit);

  always_comb begin
    sram_a    = cpu_sram_a;
    ramcs_b   = cpu_ramcs_b;
    sram_we_b = WR_B;
    sram_oe_b = RAMRD_B;
    RAMDIS    = cpu_ramdis;
    READY     = 1'b1;
    dma_ack   = (state_reg == DMA_ACK);
    if (dma_owns) begin
      sram_a    = dma_addr;
      ramcs_b   = 1'b0;
      sram_we_b = ~dma_we;
      sram_oe_b = dma_we;
      RAMDIS    = 1'b0;
    end
    if (WAIT_EN && (state_reg == DMA_ACC) && cpu_hit) begin
      READY = 1'b0;
    end
    // Reset releases the SRAM and bus immediately, not at the next edge.
    if (RESET) begin
      ramcs_b   = 1'b1;
      sram_we_b = 1'b1;
      sram_oe_b = 1'b1;
      RAMDIS    = 1'b0;
      READY     = 1'b1;
      dma_ack   = 1'b0;
    end
  end

endmodule
